alu_encoder_writer: RTL and testbench
=====================================

# alu_encoder_writer

Streaming encoder and memory writer for ALU-class instructions; the encoding counterpart of the ALU instruction decoder. It accepts decoded instruction fields over a valid/ready handshake and packs each set into a 16-bit instruction word. Words pass through a small FIFO and are written sequentially into instruction memory starting at a programmed base address. It sits between the loader/debug front end and the instruction memory write port, so programs can be generated in hardware instead of being preassembled.

## Interface
- FIFO_DEPTH, 4, encoded-word buffer entries (power of two, ≥2)
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; loads base_address/length, begins a run (ignored unless IDLE)
- base_address  in  16  first memory address written
- length  in  16  number of instructions to accept this run
- in_valid  in  1  field tuple present
- in_ready  out  1  tuple accepted when in_valid && in_ready
- alu_code  in  5  ALU operation
- source_select  in  3  source register/memory selector
- destination_select  in  2  destination selector
- increment  in  1  post-increment flag
- effect  in  2  effect code (effect[0] doubles as sign/decrement)
- mem_write_enable  out  1  write request
- mem_address  out  16  write address
- mem_data  out  16  encoded instruction word
- mem_ready  in  1  memory accepts the write this cycle
- busy  out  1  state is RUN or DRAIN
- done  out  1  one-cycle pulse at end of run
- written_count  out  16  words written in current/last run

## Operation
- Encoding (combinational on accept): word[15]=1 (ALU class), [14:13]=effect, [12]=increment, [11:10]=destination_select, [9:7]=source_select, [6:2]=alu_code, [1:0]=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start with length≠0 → RUN; address←base_address, accepted←0, written_count←0. start with length=0 → DONE.
- RUN: in_ready = !fifo_full && accepted<length. On accept, push word, accepted+1. When accepted==length → DRAIN.
- DRAIN: in_ready=0; when FIFO empty and no write pending → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- Write side (RUN and DRAIN): mem_write_enable = !fifo_empty; mem_data = FIFO head; mem_address = address. When mem_write_enable && mem_ready: pop, address+1 (wraps FFFF→0000), written_count+1.
- Push and pop in the same cycle are legal; occupancy is unchanged.
- start while busy or in DONE is ignored. in_valid outside RUN is ignored; nothing is pushed.
- Reset at any point: state IDLE, FIFO emptied, counters and address zero. In-flight words are discarded and no write is issued after reset deasserts.

## Timing
- Reset values: in_ready=0, mem_write_enable=0, mem_address=0, mem_data=0 (empty head reads 0), busy=0, done=0, written_count=0.
- start at cycle N → busy=1 and in_ready=1 at N+1.
- Accept at cycle N (FIFO empty) → mem_write_enable=1 with that word at N+1. Minimum latency is 1 cycle.
- Throughput: 1 word/cycle while mem_ready=1.
- Full FIFO: in_ready=0 in the same cycle occupancy reaches FIFO_DEPTH (registered). It reasserts the cycle after a pop.
- mem_ready low stalls: mem_address and mem_data are held stable until accepted.
- Final write accepted at cycle N → DONE (done=1) at N+1, IDLE and busy=0 at N+2.
- length=0: start at N → done=1 at N+1; no memory write.

## Test plan
- Single word: base_address=0x0100, length=1, fields alu_code=0x0A, src=001, dst=10, increment=1, effect=01 → one write 0xB8A8 @0x0100, done pulse, written_count=1.
- All-zero fields, length=3 back-to-back, mem_ready=1 → 0x8000 written to base, base+1, base+2 on consecutive cycles; done 1 cycle after the last write.
- Backpressure: mem_ready=0 for 10 cycles, length=8, in_valid always 1 → exactly FIFO_DEPTH accepts, then in_ready=0 with address/data held. After release, all 8 are written in order.
- Wrap: base_address=0xFFFE, length=4 → addresses FFFE, FFFF, 0000, 0001.
- length=0, and start while busy → done at N+1 with no writes; a mid-run start leaves address/length unchanged.
- Reset asserted mid-DRAIN with 2 words queued → all outputs go to reset values immediately and no further mem_write_enable is issued; a new run afterwards behaves normally.

Source files
------------

// File: rtl/alu_encoder_writer.sv
// ALU-class instruction encoder feeding a small FIFO that streams
// encoded words into instruction memory from a programmed base address.
module alu_encoder_writer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] base_address,
    input  logic [15:0] length,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  alu_code,
    input  logic [2:0]  source_select,
    input  logic [1:0]  destination_select,
    input  logic        increment,
    input  logic [1:0]  effect,
    output logic        mem_write_enable,
    output logic [15:0] mem_address,
    output logic [15:0] mem_data,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] written_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   address_q, address_d;
    logic [15:0]   length_q, length_d;
    logic [15:0]   accepted_q, accepted_d;
    logic [15:0]   written_q, written_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [15:0]   fifo_q [FIFO_DEPTH];
    logic [15:0]   fifo_d [FIFO_DEPTH];

    logic          active;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [15:0]   word;

    always_comb begin
        word = {1'b1, effect, increment, destination_select,
                source_select, alu_code, 2'b00};
    end

    assign active           = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign fifo_empty       = (count_q == '0);
    assign fifo_full        = (count_q == FULL);
    assign in_ready         = (state_q == S_RUN) && !fifo_full
                              && (accepted_q < length_q);
    assign push             = in_valid && in_ready;
    assign mem_write_enable = active && !fifo_empty;
    assign pop              = mem_write_enable && mem_ready;
    // An empty FIFO presents zero rather than a stale entry
    assign mem_data         = fifo_empty ? 16'h0000 : fifo_q[rd_ptr_q];
    assign mem_address      = address_q;
    assign busy             = active;
    assign done             = (state_q == S_DONE);
    assign written_count    = written_q;

    always_comb begin
        state_d    = state_q;
        address_d  = address_q;
        length_d   = length_q;
        accepted_d = accepted_q;
        written_d  = written_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        fifo_d     = fifo_q;

        if (push) begin
            fifo_d[wr_ptr_q] = word;
            wr_ptr_d         = wr_ptr_q + 1'b1;
            accepted_d       = accepted_q + 16'd1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            address_d = address_q + 16'd1;
            written_d = written_q + 16'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != 16'd0) begin
                        state_d    = S_RUN;
                        address_d  = base_address;
                        length_d   = length;
                        accepted_d = 16'd0;
                        written_d  = 16'd0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (accepted_d == length_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (count_d == '0) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            address_q  <= '0;
            length_q   <= '0;
            accepted_q <= '0;
            written_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            address_q  <= address_d;
            length_q   <= length_d;
            accepted_q <= accepted_d;
            written_q  <= written_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the occupancy count gates every read
    always_ff @(posedge clock) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_alu_encoder_writer.sv
// Scoreboard bench for alu_encoder_writer: directed runs with
// hand-encoded words, checked by an independent write monitor.
module tb_alu_encoder_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_address = '0;
    logic [15:0] length = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alu_code = '0;
    logic [2:0]  source_select = '0;
    logic [1:0]  destination_select = '0;
    logic        increment = 1'b0;
    logic [1:0]  effect = '0;
    logic        mem_write_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_data;
    logic        mem_ready = 1'b1;
    logic        busy;
    logic        done;
    logic [15:0] written_count;

    alu_encoder_writer #(.FIFO_DEPTH(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .base_address       (base_address),
        .length             (length),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .alu_code           (alu_code),
        .source_select      (source_select),
        .destination_select (destination_select),
        .increment          (increment),
        .effect             (effect),
        .mem_write_enable   (mem_write_enable),
        .mem_address        (mem_address),
        .mem_data           (mem_data),
        .mem_ready          (mem_ready),
        .busy               (busy),
        .done               (done),
        .written_count      (written_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Hand-encoded field vectors and their words
    logic [4:0]  t_alu [9] = '{5'h1F, 5'h00, 5'h01, 5'h00, 5'h00,
                               5'h00, 5'h00, 5'h15, 5'h0A};
    logic [2:0]  t_src [9] = '{3'd7, 3'd0, 3'd0, 3'd1, 3'd0,
                               3'd0, 3'd0, 3'd5, 3'd1};
    logic [1:0]  t_dst [9] = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd1,
                               2'd0, 2'd0, 2'd2, 2'd2};
    logic        t_inc [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  t_eff [9] = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd0,
                               2'd0, 2'd2, 2'd1, 2'd1};
    logic [15:0] t_word [9] = '{16'hFFFC, 16'h8000, 16'h8004, 16'h8080,
                                16'h8400, 16'h9000, 16'hC000, 16'hAAD4,
                                16'hB8A8};

    logic [31:0] exp_q [$];
    logic [31:0] mon_e;
    logic [15:0] exp_addr;
    int          wr_count = 0;
    int          wr_cyc [$];
    int          last_wr_cyc = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && mem_write_enable && mem_ready) begin
            wr_count++;
            wr_cyc.push_back(cyc);
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got %h@%h expected none",
                         mem_data, mem_address);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr_data", {mem_address, mem_data}, mon_e);
            end
        end
    end

    task automatic set_fields(input int k);
        alu_code           = t_alu[k];
        source_select      = t_src[k];
        destination_select = t_dst[k];
        increment          = t_inc[k];
        effect             = t_eff[k];
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] l);
        @(posedge clock); #1;
        start        = 1'b1;
        base_address = b;
        length       = l;
        start_cyc    = cyc;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send(input int k, input bit expect_write);
        bit ok;
        ok = 0;
        set_fields(k);
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1;
                if (expect_write) begin
                    exp_q.push_back({exp_addr, t_word[k]});
                    exp_addr = exp_addr + 16'd1;
                end
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end
    endtask

    task automatic finish_run(input logic [15:0] n);
        bit got;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock);
            if (done) begin
                got = 1;
                done_cyc = cyc;
            end
        end
        chk("done_seen", got, 1);
        chk("done_timing", done_cyc, last_wr_cyc + 1);
        @(negedge clock);
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        chk("written_count", written_count, n);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        int k;
        int bad;
        int wc0;
        logic [15:0] held_a;
        logic [15:0] held_d;
        bit held_ok;

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_write_enable, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_wcount", written_count, 0);
        reset = 1'b0;

        // Single word
        exp_addr = 16'h0100;
        do_start(16'h0100, 16'd1);
        chk("start_busy", busy, 1);
        chk("start_in_ready", in_ready, 1);
        send(8, 1);
        @(negedge clock);
        chk("latency_we", mem_write_enable, 1);
        chk("latency_data", mem_data, 16'hB8A8);
        finish_run(16'd1);

        // All-zero fields back-to-back
        wr_cyc.delete();
        exp_addr = 16'h0200;
        do_start(16'h0200, 16'd3);
        send(1, 1);
        send(1, 1);
        send(1, 1);
        finish_run(16'd3);
        chk("b2b_nwrites", wr_cyc.size(), 3);
        chk("b2b_consecutive",
            (wr_cyc.size() == 3) ? wr_cyc[2] - wr_cyc[0] : -1, 2);

        // Backpressure
        mem_ready = 1'b0;
        exp_addr = 16'h0300;
        do_start(16'h0300, 16'd8);
        k = 0;
        held_ok = 0;
        bad = 0;
        held_a = '0;
        held_d = '0;
        set_fields(0);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (in_ready) begin
                exp_q.push_back({exp_addr, t_word[k]});
                exp_addr = exp_addr + 16'd1;
                k++;
            end
            if (mem_write_enable) begin
                if (!held_ok) begin
                    held_ok = 1;
                    held_a = mem_address;
                    held_d = mem_data;
                end else if (mem_address !== held_a || mem_data !== held_d) begin
                    bad++;
                end
            end
            @(posedge clock); #1;
            if (k < 8) set_fields(k);
        end
        chk("bp_accepts", k, 4);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_held_addr", held_a, 16'h0300);
        chk("bp_held_data", held_d, 16'hFFFC);
        chk("bp_stable", bad, 0);
        in_valid = 1'b0;
        mem_ready = 1'b1;
        for (int j = 4; j < 8; j++) send(j, 1);
        finish_run(16'd8);

        // Address wrap
        exp_addr = 16'hFFFE;
        do_start(16'hFFFE, 16'd4);
        for (int j = 0; j < 4; j++) send(j, 1);
        finish_run(16'd4);
        chk("wrap_final_addr", mem_address, 16'h0002);

        // length = 0
        wc0 = wr_count;
        do_start(16'h0900, 16'd0);
        @(negedge clock);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        @(negedge clock);
        chk("len0_done_clear", done, 0);
        chk("len0_no_write", wr_count, wc0);

        // start while busy is ignored
        exp_addr = 16'h0400;
        do_start(16'h0400, 16'd2);
        send(1, 1);
        do_start(16'h0500, 16'd5);
        send(2, 1);
        chk("midstart_in_ready", in_ready, 0);
        finish_run(16'd2);

        // Reset mid-DRAIN with two words queued
        mem_ready = 1'b0;
        do_start(16'h0600, 16'd2);
        send(3, 0);
        send(4, 0);
        chk("drain_busy", busy, 1);
        chk("drain_we", mem_write_enable, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_we", mem_write_enable, 0);
        chk("mid_rst_addr", mem_address, 0);
        chk("mid_rst_data", mem_data, 0);
        chk("mid_rst_busy_done", {busy, done}, 0);
        chk("mid_rst_wcount", written_count, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        mem_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (mem_write_enable) bad++;
        end
        chk("post_rst_no_write", bad, 0);

        exp_addr = 16'h0700;
        do_start(16'h0700, 16'd2);
        send(6, 1);
        send(7, 1);
        finish_run(16'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
